// File: rtl/serial_adder_n.sv
// Multi-cycle N-bit adder: one DIGIT_W-bit slice reused per cycle, carry FF links digits.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port that loads ~b and inverts cin (a - b).
module serial_adder_n #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         a_sh, b_sh, res_sh, sum_r;
  logic                     carry, cout_r;
  logic [CNT_W-1:0]         cnt;
  logic [DIGIT_W:0]         digit;
  logic [WIDTH+DIGIT_W-1:0] res_cat;
  logic [WIDTH-1:0]         res_nxt;
  logic [WIDTH-1:0]         b_load;
  logic                     c_load;
  logic                     accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CNT_W'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = cin ^ sub;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // One digit slice; the new digit enters at the top so after N shifts the LSB digit sits lowest.
  assign digit   = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, b_sh[DIGIT_W-1:0]}
                 + {{DIGIT_W{1'b0}}, carry};
  assign res_cat = {digit[DIGIT_W-1:0], res_sh};
  assign res_nxt = res_cat[WIDTH+DIGIT_W-1:DIGIT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_load;
      res_sh <= '0;
      carry  <= c_load;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT_W;
      b_sh   <= b_sh >> DIGIT_W;
      res_sh <= res_nxt;
      carry  <= digit[DIGIT_W];
      cnt    <= cnt + CNT_W'(1);
      // Result is published only once the final digit lands, so no partial sum is ever visible.
      if (last) begin
        sum_r  <= res_nxt;
        cout_r <= digit[DIGIT_W];
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n (DIGIT_W=1 and DIGIT_W=4 instances).
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       ready, busy, done, cout;
  logic [7:0] sum;
  logic       ready4, busy4, done4, cout4;
  logic [7:0] sum4;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_n #(.WIDTH(8), .DIGIT_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Accept one operation on dut, then check latency, result, hold-during-RUN and return to IDLE.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts, input logic [7:0] esum, input logic ecout);
    logic [7:0] prev;
    logic       held;
    int         lat;
    prev = sum;
    held = 1'b1;
    lat  = 0;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {30'd0, ready, busy}, 32'b01);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (sum !== prev) held = 1'b0;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_hold"}, held, 1);
    chk({tag, "_res"}, {23'd0, cout, sum}, {23'd0, ecout, esum});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {29'd0, ready, busy, done}, 32'b100);
  endtask

  initial begin
    int ndone;
    int t0;
    int t1;
    logic [7:0] cap;
    #2;
    chk("rst_state", {21'd0, ready, busy, done, cout, sum}, {21'd0, 4'b1000, 8'h00});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    do_op("ff_1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
    do_op("mix", 8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0);

    // start during RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    cap = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; cap = sum; end
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 4) start = 1'b0;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_sum", {24'd0, cap}, 32'h30);
    chk("ign_cout", cout, 0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {21'd0, ready, busy, done, cout, sum}, {21'd0, 4'b1000, 8'h00});
    ndone = 0;
    repeat (10) begin @(posedge clk); #1; if (done) ndone++; end
    chk("rst_nodone", ndone, 0);
    @(negedge clk); rst_n = 1'b1;
    do_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

    // start held high re-triggers every N+2 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t0 < 0) t0 = cyc;
        else begin t1 = cyc; break; end
      end
    end
    start = 1'b0;
    chk("retrig_period", t1 - t0, 10);
    chk("retrig_sum", {24'd0, sum}, 32'h02);
    repeat (2) @(posedge clk);
    #1;

    // DIGIT_W=4 instance: two-cycle latency
    @(negedge clk);
    a = 8'h9C; b = 8'h68; cin = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      t0++;
      if (done4) break;
    end
    chk("d4_lat", t0, 2);
    chk("d4_res", {23'd0, cout4, sum4}, {23'd0, 1'b1, 8'h04});
    @(posedge clk); #1;
    chk("d4_idle", {30'd0, ready4, done4}, 32'b10);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    do_op("sub_pos", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
